lfsr_gen: RTL and testbench

Parametrised LFSR pseudo-random generator, the successor to the fixed 16-bit Fibonacci LFSR. It adds generic width, a selectable Fibonacci or Galois structure, step enable, runtime reseed, and all-zero lock-up recovery. An optional period monitor flags when the sequence returns to its start state. It is used as a stimulus/PRBS source and scrambler seed generator in lab designs.

---
 rtl/lfsr_gen.sv | 126 ++++++++++++
 tb/tb_lfsr_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_gen                                                        |
// | Purpose  : Parametrised LFSR pseudo-random generator. Fibonacci or Galois  |
// |            structure, step enable, runtime reseed and all-zero lock-up      |
// |            recovery. Define LFSR_PERIOD_MON_EN to build the period monitor  |
// |            (wrap/period outputs); otherwise those outputs are tied to 0.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lfsr_gen #(
  parameter int          WIDTH     = 16,
  parameter int          GALOIS    = 0,
  parameter logic [31:0] TAPS      = 32'h0000_B400,
  parameter logic [31:0] GMASK     = 32'h0000_002D,
  parameter logic [31:0] LOCK_SEED = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] init,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             zero_fix,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  // Only the low WIDTH bits of the mask/seed parameters are meaningful.
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] G_MASK   = GMASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LOCK_VAL = LOCK_SEED[WIDTH-1:0];

  // Parameter sanity checks: refuse to elaborate an unusable configuration.
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..32");
  end
  if (TAP_MASK[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_gen: TAPS bit WIDTH-1 must be set");
  end
  if (LOCK_VAL == '0) begin : g_bad_lock
    $error("lfsr_gen: LOCK_SEED must be nonzero in the low WIDTH bits");
  end

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] raw_step;
  logic             step_zero;
  logic [WIDTH-1:0] step_val;
  logic             seed_zero;
  logic [WIDTH-1:0] seed_val;
  logic             init_zero;
  logic [WIDTH-1:0] init_val;

  // Next-state candidates for step, reseed and reset, each with zero substitution.
  always_comb begin
    shifted = {out[WIDTH-2:0], 1'b0};
    if (GALOIS != 0) begin
      raw_step = shifted ^ (out[WIDTH-1] ? G_MASK : '0);
    end else begin
      raw_step = {out[WIDTH-2:0], ^(out & TAP_MASK)};
    end
    step_zero = (raw_step == '0);
    step_val  = step_zero ? LOCK_VAL : raw_step;
    seed_zero = (seed == '0);
    seed_val  = seed_zero ? LOCK_VAL : seed;
    init_zero = (init == '0);
    init_val  = init_zero ? LOCK_VAL : init;
  end

  // LFSR state register: reset > load > step > hold; zero_fix is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      out      <= init_val;
      zero_fix <= init_zero;
    end else if (load) begin
      out      <= seed_val;
      zero_fix <= seed_zero;
    end else if (en) begin
      out      <= step_val;
      zero_fix <= step_zero;
    end else begin
      zero_fix <= 1'b0;
    end
  end

`ifdef LFSR_PERIOD_MON_EN
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] start;

  // Period monitor: counts steps since the start state and reports the cycle length.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      count  <= '0;
      start  <= init_val;
      wrap   <= 1'b0;
      period <= '0;
    end else if (load) begin
      count <= '0;
      start <= seed_val;
      wrap  <= 1'b0;
    end else if (en) begin
      if (step_zero) begin
        // A lock-up substitution jumps into a new sequence; measure from there.
        count <= '0;
        start <= LOCK_VAL;
        wrap  <= 1'b0;
      end else if (step_val == start) begin
        count  <= '0;
        wrap   <= 1'b1;
        period <= count + WIDTH'(1);
      end else begin
        count <= count + WIDTH'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end
`else
  // Monitor not built: keep the ports with fixed values.
  assign wrap   = 1'b0;
  assign period = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lfsr_gen                                                     |
// | Purpose  : Directed, table-driven checks of lfsr_gen in Fibonacci, Galois,  |
// |            small-width and lock-up configurations.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lfsr_gen;

`ifdef LFSR_PERIOD_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic clk;
  int   total;
  int   bad;

  // dut0: default 16-bit Fibonacci
  logic        rn0, ld0, en0;
  logic [15:0] init0, seed0, out0, per0;
  logic        zf0, wr0;
  // dut1: 16-bit Galois
  logic        rn1, ld1, en1;
  logic [15:0] init1, seed1, out1, per1;
  logic        zf1, wr1;
  // dut2: 4-bit Fibonacci, taps 4'hC (maximal length 15)
  logic        rn2, ld2, en2;
  logic [3:0]  init2, seed2, out2, per2;
  logic        zf2, wr2;
  // dut3: 4-bit Galois with empty mask, so a step can reach zero
  logic        rn3, ld3, en3;
  logic [3:0]  init3, seed3, out3, per3;
  logic        zf3, wr3;

  lfsr_gen u_dut0 (
    .clk(clk), .nReset(rn0), .init(init0), .en(en0), .load(ld0), .seed(seed0),
    .out(out0), .zero_fix(zf0), .wrap(wr0), .period(per0)
  );

  lfsr_gen #(.GALOIS(1)) u_dut1 (
    .clk(clk), .nReset(rn1), .init(init1), .en(en1), .load(ld1), .seed(seed1),
    .out(out1), .zero_fix(zf1), .wrap(wr1), .period(per1)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(32'hC), .GMASK(32'h3), .LOCK_SEED(32'h1)) u_dut2 (
    .clk(clk), .nReset(rn2), .init(init2), .en(en2), .load(ld2), .seed(seed2),
    .out(out2), .zero_fix(zf2), .wrap(wr2), .period(per2)
  );

  lfsr_gen #(.WIDTH(4), .GALOIS(1), .TAPS(32'h8), .GMASK(32'h0), .LOCK_SEED(32'h3)) u_dut3 (
    .clk(clk), .nReset(rn3), .init(init3), .en(en3), .load(ld3), .seed(seed3),
    .out(out3), .zero_fix(zf3), .wrap(wr3), .period(per3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        ld;
    logic        step;
    logic [15:0] sd;
    logic [15:0] ini;
    logic [15:0] exp_out;
    logic        exp_zf;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected 4-bit sequence for taps 4'hC starting at 1 (index = steps mod 15).
  logic [3:0] seq4 [15];

  initial begin
    total = 0;
    bad   = 0;
    rn0 = 1'b0; ld0 = 1'b0; en0 = 1'b0; init0 = 16'h0; seed0 = 16'h0;
    rn1 = 1'b0; ld1 = 1'b0; en1 = 1'b0; init1 = 16'h8000; seed1 = 16'h0;
    rn2 = 1'b0; ld2 = 1'b0; en2 = 1'b0; init2 = 4'h1; seed2 = 4'h0;
    rn3 = 1'b0; ld3 = 1'b0; en3 = 1'b0; init3 = 4'h4; seed3 = 4'h0;

    seq4 = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    //            rst_n ld    en    seed      init      exp_out   zf
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0400, 16'h0400, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0801, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1002, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1002, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h2469, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0002, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0004, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0008, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0010, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0020, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0040, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0080, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 16'h5555, 16'hACE1, 16'hACE1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h59C3, 1'b0};

    // Default Fibonacci: table of reset/load/step/hold vectors.
    for (int i = 0; i < 18; i++) begin
      rn0   = vecs[i].rst_n;
      ld0   = vecs[i].ld;
      en0   = vecs[i].step;
      seed0 = vecs[i].sd;
      init0 = vecs[i].ini;
      tick();
      check($sformatf("fib_out[%0d]", i), 32'(out0), 32'(vecs[i].exp_out));
      check($sformatf("fib_zf[%0d]", i), 32'(zf0), 32'(vecs[i].exp_zf));
      check($sformatf("fib_wrap[%0d]", i), 32'(wr0), 32'd0);
      check($sformatf("fib_period[%0d]", i), 32'(per0), 32'd0);
    end

    // Hold: 10 idle cycles leave the state untouched.
    ld0 = 1'b0; en0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("fib_hold[%0d]", i), 32'(out0), 32'h59C3);
    end

    // Galois: reset to 8000, then two steps.
    init1 = 16'h8000; rn1 = 1'b0;
    tick();
    check("gal_reset", 32'(out1), 32'h8000);
    rn1 = 1'b1; en1 = 1'b1;
    tick();
    check("gal_step1", 32'(out1), 32'h002D);
    check("gal_step1_zf", 32'(zf1), 32'd0);
    tick();
    check("gal_step2", 32'(out1), 32'h005A);
    en1 = 1'b0;

    // Lock-up guard: 4 -> 8 -> (zero replaced by 3) -> 6.
    init3 = 4'h4; rn3 = 1'b0;
    tick();
    check("lock_reset", 32'(out3), 32'h4);
    rn3 = 1'b1; en3 = 1'b1;
    tick();
    check("lock_step1", 32'(out3), 32'h8);
    check("lock_step1_zf", 32'(zf3), 32'd0);
    tick();
    check("lock_step2", 32'(out3), 32'h3);
    check("lock_step2_zf", 32'(zf3), 32'd1);
    tick();
    check("lock_step3", 32'(out3), 32'h6);
    check("lock_step3_zf", 32'(zf3), 32'd0);
    en3 = 1'b0;

    // 4-bit maximal sequence with period monitoring over two full cycles.
    init2 = 4'h1; rn2 = 1'b0;
    tick();
    check("w4_reset", 32'(out2), 32'h1);
    check("w4_reset_period", 32'(per2), 32'd0);
    rn2 = 1'b1; en2 = 1'b1;
    for (int s = 1; s <= 30; s++) begin
      tick();
      check($sformatf("w4_out[%0d]", s), 32'(out2), 32'(seq4[s % 15]));
      check($sformatf("w4_wrap[%0d]", s), 32'(wr2), 32'(MON && (s % 15 == 0)));
      check($sformatf("w4_period[%0d]", s), 32'(per2), (MON && s >= 15) ? 32'd15 : 32'd0);
    end
    en2 = 1'b0;
    tick();
    check("w4_wrap_drop", 32'(wr2), 32'd0);
    check("w4_idle_out", 32'(out2), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
